// File: rtl/dwrr_flow_scheduler.sv
// Deficit-weighted round-robin packet scheduler.
// Scans flows with queued packets, queries each flow's credit from dwrr_credits,
// grants one packet at a time to egress, charges one credit per granted packet and
// signals replenishment at end of packet or when a full scan finds nothing grantable.
//
// Ports:
//   clk, rstn               clock, asynchronous active-low reset
//   init_done               credit tables ready; sampled only while idle
//   flow_nonempty           bit i set = flow i has a complete packet queued
//   flow_check              flow currently queried in dwrr_credits
//   flow_credit_value       credit of flow_check, valid CREDIT_LAT cycles after it changes
//   consume_credit_valid    one-cycle pulse, one credit consumed from consume_credit_flow
//   consume_credit_flow     flow charged
//   packet_tlast            one-cycle pulse, add credits (end of packet or starvation)
//   grant_valid, grant_flow grant offered to egress, flow held stable until grant_ready
//   grant_ready             egress accepts the grant
//   pkt_done                egress moved the last beat of the granted packet
//   starve_count            saturating count of starvation replenish pulses
module dwrr_flow_scheduler #(
    parameter int unsigned FLOW_W       = 3,
    parameter int unsigned MAX_CREDIT_W = 3,
    parameter int unsigned CREDIT_LAT   = 2,
    parameter int unsigned MAX_BURST    = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    init_done,
    input  logic [(2**FLOW_W)-1:0]  flow_nonempty,
    output logic [FLOW_W-1:0]       flow_check,
    input  logic [MAX_CREDIT_W-1:0] flow_credit_value,
    output logic                    consume_credit_valid,
    output logic [FLOW_W-1:0]       consume_credit_flow,
    output logic                    packet_tlast,
    output logic                    grant_valid,
    output logic [FLOW_W-1:0]       grant_flow,
    input  logic                    grant_ready,
    input  logic                    pkt_done,
    output logic [7:0]              starve_count
);

    localparam int unsigned NUM_FLOWS = 2**FLOW_W;
    localparam int unsigned BURST_W   = 4;
    localparam int unsigned WAIT_W    = 3;
    localparam int unsigned SCAN_W    = FLOW_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_EVAL,
        S_GRANT,
        S_XFER
    } state_t;

    state_t              state;
    logic [FLOW_W-1:0]   rr_ptr;
    logic [BURST_W-1:0]  burst_cnt;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [SCAN_W-1:0]   scan_cnt;
    logic                eligible;

    // Flow at rr_ptr may send another packet this visit
    assign eligible = flow_nonempty[rr_ptr]
                   && (flow_credit_value != '0)
                   && (burst_cnt < BURST_W'(MAX_BURST));

    // Scheduler FSM; every output is a register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state                <= S_IDLE;
            rr_ptr               <= '0;
            burst_cnt            <= '0;
            wait_cnt             <= '0;
            scan_cnt             <= '0;
            flow_check           <= '0;
            consume_credit_valid <= 1'b0;
            consume_credit_flow  <= '0;
            packet_tlast         <= 1'b0;
            grant_valid          <= 1'b0;
            grant_flow           <= '0;
            starve_count         <= '0;
        end else begin
            consume_credit_valid <= 1'b0;
            packet_tlast         <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (init_done && (flow_nonempty != '0)) begin
                        state      <= S_CHECK;
                        flow_check <= rr_ptr;
                        wait_cnt   <= '0;
                    end
                end

                // Give dwrr_credits CREDIT_LAT cycles to return the queried credit
                S_CHECK: begin
                    if (wait_cnt == WAIT_W'(CREDIT_LAT - 1)) begin
                        state <= S_EVAL;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end

                S_EVAL: begin
                    if (flow_nonempty == '0) begin
                        state <= S_IDLE;
                    end else if (eligible) begin
                        state       <= S_GRANT;
                        grant_valid <= 1'b1;
                        grant_flow  <= rr_ptr;
                        scan_cnt    <= '0;
                    end else begin
                        // Move on; the pointer wraps naturally at NUM_FLOWS
                        rr_ptr     <= rr_ptr + FLOW_W'(1);
                        flow_check <= rr_ptr + FLOW_W'(1);
                        burst_cnt  <= '0;
                        wait_cnt   <= '0;
                        state      <= S_CHECK;
                        // A whole lap without a grant: ask dwrr_credits to replenish
                        if (scan_cnt == SCAN_W'(NUM_FLOWS - 1)) begin
                            packet_tlast <= 1'b1;
                            scan_cnt     <= '0;
                            if (starve_count != 8'hFF) begin
                                starve_count <= starve_count + 8'd1;
                            end
                        end else begin
                            scan_cnt <= scan_cnt + SCAN_W'(1);
                        end
                    end
                end

                S_GRANT: begin
                    if (grant_ready) begin
                        grant_valid          <= 1'b0;
                        consume_credit_valid <= 1'b1;
                        consume_credit_flow  <= grant_flow;
                        burst_cnt            <= burst_cnt + BURST_W'(1);
                        if (pkt_done) begin
                            // Single-beat packet: tlast lands with the consume pulse
                            packet_tlast <= 1'b1;
                            state        <= S_CHECK;
                            flow_check   <= rr_ptr;
                            wait_cnt     <= '0;
                        end else begin
                            state <= S_XFER;
                        end
                    end
                end

                // Same flow is re-checked afterwards to spend any remaining deficit
                S_XFER: begin
                    if (pkt_done) begin
                        packet_tlast <= 1'b1;
                        state        <= S_CHECK;
                        flow_check   <= rr_ptr;
                        wait_cnt     <= '0;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dwrr_flow_scheduler.sv
// Testbench for dwrr_flow_scheduler: a credit table with CREDIT_LAT read latency stands
// in for dwrr_credits; an untimed scan model predicts the grant order up to the first
// starvation replenish, and an egress driver applies random ready/done delays.
module tb_dwrr_flow_scheduler;

    localparam int unsigned FLOW_W       = 3;
    localparam int unsigned NUM_FLOWS    = 8;
    localparam int unsigned MAX_CREDIT_W = 3;
    localparam int unsigned CREDIT_LAT   = 2;
    localparam int unsigned MAX_BURST    = 4;
    localparam int          CYC_LIMIT    = 3000;

    logic                    clk = 1'b0;
    logic                    rstn;
    logic                    init_done;
    logic [NUM_FLOWS-1:0]    flow_nonempty;
    logic [FLOW_W-1:0]       flow_check;
    logic [MAX_CREDIT_W-1:0] flow_credit_value;
    logic                    consume_credit_valid;
    logic [FLOW_W-1:0]       consume_credit_flow;
    logic                    packet_tlast;
    logic                    grant_valid;
    logic [FLOW_W-1:0]       grant_flow;
    logic                    grant_ready;
    logic                    pkt_done;
    logic [7:0]              starve_count;

    int tests_run    = 0;
    int tests_failed = 0;

    dwrr_flow_scheduler #(
        .FLOW_W      (FLOW_W),
        .MAX_CREDIT_W(MAX_CREDIT_W),
        .CREDIT_LAT  (CREDIT_LAT),
        .MAX_BURST   (MAX_BURST)
    ) dut (
        .clk                 (clk),
        .rstn                (rstn),
        .init_done           (init_done),
        .flow_nonempty       (flow_nonempty),
        .flow_check          (flow_check),
        .flow_credit_value   (flow_credit_value),
        .consume_credit_valid(consume_credit_valid),
        .consume_credit_flow (consume_credit_flow),
        .packet_tlast        (packet_tlast),
        .grant_valid         (grant_valid),
        .grant_flow          (grant_flow),
        .grant_ready         (grant_ready),
        .pkt_done            (pkt_done),
        .starve_count        (starve_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        tests_run++;
        if (got != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Credit source: consumption is forwarded into the read pipe so a re-check sees it
    logic [MAX_CREDIT_W-1:0] cred     [NUM_FLOWS];
    logic [MAX_CREDIT_W-1:0] load_val [NUM_FLOWS];
    logic [MAX_CREDIT_W-1:0] cpipe    [CREDIT_LAT];
    logic [MAX_CREDIT_W-1:0] eff;
    logic                    load = 1'b0;

    always_comb begin
        eff = cred[flow_check];
        if (consume_credit_valid && consume_credit_flow == flow_check && eff != '0)
            eff = eff - 3'd1;
    end

    always @(posedge clk) begin
        cpipe[0] <= eff;
        for (int i = 1; i < int'(CREDIT_LAT); i++) cpipe[i] <= cpipe[i-1];
        if (load) begin
            for (int i = 0; i < int'(NUM_FLOWS); i++) cred[i] <= load_val[i];
        end else if (consume_credit_valid && cred[consume_credit_flow] != '0) begin
            cred[consume_credit_flow] <= cred[consume_credit_flow] - 3'd1;
        end
    end

    assign flow_credit_value = cpipe[CREDIT_LAT-1];

    // Expected grant order: visit flows in ring order, spend credit up to the burst
    // limit per visit, stop once a full lap grants nothing
    int exp_q[$];

    task automatic build_expected(input logic [NUM_FLOWS-1:0] mask);
        int cr[NUM_FLOWS];
        int ptr   = 0;
        int burst = 0;
        int scan  = 0;
        exp_q.delete();
        for (int i = 0; i < int'(NUM_FLOWS); i++) cr[i] = int'(load_val[i]);
        for (int n = 0; n < 2000; n++) begin
            if (mask[ptr] && cr[ptr] > 0 && burst < int'(MAX_BURST)) begin
                exp_q.push_back(ptr);
                cr[ptr]--;
                burst++;
                scan = 0;
            end else begin
                ptr   = (ptr + 1) % int'(NUM_FLOWS);
                burst = 0;
                scan++;
                if (scan == int'(NUM_FLOWS)) break;
            end
        end
    endtask

    task automatic clear_credits();
        for (int i = 0; i < int'(NUM_FLOWS); i++) load_val[i] = '0;
    endtask

    // Reset the DUT, load credits, then release with init_done high
    task automatic start_scenario(input logic [NUM_FLOWS-1:0] mask);
        rstn          = 1'b0;
        init_done     = 1'b0;
        grant_ready   = 1'b0;
        pkt_done      = 1'b0;
        flow_nonempty = mask;
        load          = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        load = 1'b0;
        @(posedge clk);
        #1;
        rstn      = 1'b1;
        init_done = 1'b1;
    endtask

    // rdy_force / pd_force < 0 pick random delays per packet
    task automatic run_scenario(input string tag, input logic [NUM_FLOWS-1:0] mask,
                                input int rdy_force, input int pd_force);
        int cyc = 0, gidx = 0, phase = 0, rdy_wait = 0, pd_wait = 0, rem = 0;
        int held_flow = 0, cons_flow = 0, fc_change = 0;
        bit exp_cons = 0, exp_tlast = 0, drop_chk = 0, starved = 0, first = 1, fresh = 0;
        logic [FLOW_W-1:0] prev_fc;

        build_expected(mask);
        start_scenario(mask);
        prev_fc = flow_check;

        while (!starved && cyc < CYC_LIMIT) begin
            @(posedge clk);
            #1;
            cyc++;
            grant_ready = 1'b0;
            pkt_done    = 1'b0;
            if (flow_check != prev_fc) begin
                fc_change = cyc;
                prev_fc   = flow_check;
            end

            if (exp_cons) begin
                check_eq({tag, " consume_valid"}, int'(consume_credit_valid), 1);
                check_eq({tag, " consume_flow"}, int'(consume_credit_flow), cons_flow);
                exp_cons = 0;
            end else begin
                check_eq({tag, " idle consume"}, int'(consume_credit_valid), 0);
            end

            if (drop_chk) begin
                check_eq({tag, " grant drop"}, int'(grant_valid), 0);
                drop_chk = 0;
            end

            if (exp_tlast) begin
                check_eq({tag, " tlast"}, int'(packet_tlast), 1);
                exp_tlast = 0;
            end else if (packet_tlast) begin
                // Unsolicited tlast must be the starvation replenish
                check_eq({tag, " starve_count"}, int'(starve_count), 1);
                check_eq({tag, " grants before starve"}, gidx, exp_q.size());
                starved = 1;
            end

            if (phase == 0 && grant_valid) begin
                if (gidx < exp_q.size())
                    check_eq({tag, " grant_flow"}, int'(grant_flow), exp_q[gidx]);
                else
                    check_eq({tag, " extra grant"}, gidx, exp_q.size());
                if (first && grant_flow != '0)
                    check_eq({tag, " eval latency"}, cyc - fc_change, int'(CREDIT_LAT) + 1);
                first     = 0;
                held_flow = int'(grant_flow);
                gidx++;
                rdy_wait  = (rdy_force >= 0) ? rdy_force : int'($urandom_range(0, 3));
                pd_wait   = (pd_force  >= 0) ? pd_force  : int'($urandom_range(0, 3));
                phase     = 1;
                fresh     = 1;
            end

            if (phase == 1) begin
                if (!fresh) begin
                    check_eq({tag, " hold valid"}, int'(grant_valid), 1);
                    check_eq({tag, " hold flow"}, int'(grant_flow), held_flow);
                end
                fresh = 0;
                if (rdy_wait == 0) begin
                    grant_ready = 1'b1;
                    exp_cons    = 1;
                    drop_chk    = 1;
                    cons_flow   = held_flow;
                    if (pd_wait == 0) begin
                        pkt_done  = 1'b1;
                        exp_tlast = 1;
                        phase     = 0;
                    end else begin
                        phase = 2;
                    end
                end else begin
                    rdy_wait--;
                end
            end else if (phase == 2) begin
                rem = pd_wait - 1;
                if (rem == 0) begin
                    pkt_done  = 1'b1;
                    exp_tlast = 1;
                    phase     = 0;
                end else begin
                    phase = 3;
                end
            end else if (phase == 3) begin
                check_eq({tag, " single outstanding"}, int'(grant_valid), 0);
                rem--;
                if (rem == 0) begin
                    pkt_done  = 1'b1;
                    exp_tlast = 1;
                    phase     = 0;
                end
            end
        end
        check_eq({tag, " reached starvation"}, int'(starved), 1);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, " grant_valid"}, int'(grant_valid), 0);
        check_eq({tag, " grant_flow"}, int'(grant_flow), 0);
        check_eq({tag, " flow_check"}, int'(flow_check), 0);
        check_eq({tag, " consume_valid"}, int'(consume_credit_valid), 0);
        check_eq({tag, " consume_flow"}, int'(consume_credit_flow), 0);
        check_eq({tag, " tlast"}, int'(packet_tlast), 0);
        check_eq({tag, " starve_count"}, int'(starve_count), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, tests run %0d", tests_run);
        $fatal(1);
    end

    initial begin
        int n;
        logic [NUM_FLOWS-1:0] m;

        // Reset with scheduling blocked by init_done
        rstn          = 1'b0;
        init_done     = 1'b0;
        grant_ready   = 1'b0;
        pkt_done      = 1'b0;
        flow_nonempty = 8'hFF;
        clear_credits();
        load = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        load = 1'b0;
        check_all_zero("reset");
        rstn = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check_all_zero("no init_done");

        clear_credits();
        load_val[2] = 3'd3;
        run_scenario("single_flow", 8'h04, 0, 2);

        clear_credits();
        load_val[0] = 3'd7;
        load_val[3] = 3'd7;
        run_scenario("burst", 8'h09, -1, -1);

        clear_credits();
        load_val[1] = 3'd1;
        run_scenario("ready_stall", 8'h02, 10, 1);

        clear_credits();
        load_val[5] = 3'd2;
        run_scenario("single_beat", 8'h20, 0, 0);

        clear_credits();
        run_scenario("all_starve", 8'hFF, -1, -1);

        for (int s = 0; s < 6; s++) begin
            m = NUM_FLOWS'($urandom_range(1, 255));
            for (int i = 0; i < int'(NUM_FLOWS); i++)
                load_val[i] = MAX_CREDIT_W'($urandom_range(0, 7));
            run_scenario($sformatf("random%0d", s), m, -1, -1);
        end

        // Reset while a packet is in flight
        clear_credits();
        load_val[2] = 3'd3;
        start_scenario(8'h04);
        n = 0;
        while (!grant_valid && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("midxfer grant seen", int'(grant_valid), 1);
        grant_ready = 1'b1;
        @(posedge clk);
        #1;
        grant_ready = 1'b0;
        check_eq("midxfer consume", int'(consume_credit_valid), 1);
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check_all_zero("midxfer reset");
        init_done = 1'b0;
        pkt_done  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rstn     = 1'b1;
        pkt_done = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            check_eq("post reset consume", int'(consume_credit_valid), 0);
            check_eq("post reset tlast", int'(packet_tlast), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
